// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: waits for PLL lock, debounces the reset button, then
// releases NumOut active-low resets in order and records the cause of the last reset.
module rst_seq_ctrl #(
    parameter int NumOut         = 4,
    parameter int HoldCycles     = 256,
    parameter int StageGap       = 16,
    parameter int DebounceCycles = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pll_locked_i,
    input  logic              rst_btn_i,
    input  logic              sw_rst_req_i,
    output logic [NumOut-1:0] rst_no,
    output logic              rst_active_o,
    output logic [1:0]        rst_cause_o
);

    localparam int CntMax = (HoldCycles > StageGap) ? HoldCycles : StageGap;
    localparam int CW     = $clog2(CntMax + 1);
    localparam int DW     = $clog2(DebounceCycles + 1);
    localparam int IW     = $clog2(NumOut + 1);

    localparam logic [CW-1:0] HoldLast = CW'(HoldCycles - 1);
    localparam logic [CW-1:0] GapLast  = CW'(StageGap - 1);
    localparam logic [DW-1:0] DbLast   = DW'(DebounceCycles - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NumOut - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_PLL = 2'd1,
        CAUSE_BTN = 2'd2,
        CAUSE_SW  = 2'd3
    } cause_t;

    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_btn_meta;
    logic              r_btn_s;
    logic              r_btn_f;
    logic [DW-1:0]     r_db_cnt;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    cause_t            r_cause;
    logic [NumOut-1:0] r_rst_n;
    logic              r_active;

    logic              w_btn_differs;
    logic              w_btn_accept;
    logic              w_btn_rise;
    logic              w_evt_pll;
    logic              w_evt_btn;
    logic              w_evt_sw;
    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [IW-1:0]     w_idx_nxt;
    cause_t            w_cause_nxt;
    logic [NumOut-1:0] w_rst_n_nxt;
    logic              w_active_nxt;

    // NOTE: sequential state uses non-blocking assignments only; mixing in
    // blocking writes here would make the flop order simulation-dependent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_s    <= r_lock_meta;
            r_btn_meta  <= rst_btn_i;
            r_btn_s     <= r_btn_meta;
        end
    end

    // The accepted button level flips on the same edge the FSM reacts to the rise.
    assign w_btn_differs = (r_btn_s != r_btn_f);
    assign w_btn_accept  = w_btn_differs && (r_db_cnt == DbLast);
    assign w_btn_rise    = w_btn_accept && r_btn_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_f  <= 1'b0;
            r_db_cnt <= '0;
        end else if (!w_btn_differs) begin
            r_db_cnt <= '0;
        end else if (w_btn_accept) begin
            r_btn_f  <= r_btn_s;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_evt_pll = !r_lock_s &&
                       (r_state == ST_HOLD || r_state == ST_RELEASE || r_state == ST_RUN);
    assign w_evt_btn = w_btn_rise &&
                       (r_state == ST_WAIT_LOCK || r_state == ST_HOLD ||
                        r_state == ST_RELEASE   || r_state == ST_RUN);
    assign w_evt_sw  = sw_rst_req_i && (r_state == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_cause  <= CAUSE_POR;
            r_rst_n  <= '0;
            r_active <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_cause  <= w_cause_nxt;
            r_rst_n  <= w_rst_n_nxt;
            r_active <= w_active_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_cause_nxt = r_cause;

        if (w_evt_pll || w_evt_btn || w_evt_sw) begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            if (w_evt_pll)      w_cause_nxt = CAUSE_PLL;
            else if (w_evt_btn) w_cause_nxt = CAUSE_BTN;
            else                w_cause_nxt = CAUSE_SW;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (!r_btn_f) w_state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HoldLast) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = IW'(1);
                        w_state_nxt = (NumOut == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == GapLast) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx == IdxLast) w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RUN:  ;
                default: w_state_nxt = ST_ASSERT;
            endcase
        end
    end

    // Outputs are a function of the next state so they register alongside it.
    always_comb begin
        w_rst_n_nxt = '0;
        case (w_state_nxt)
            ST_RUN: w_rst_n_nxt = '1;
            ST_RELEASE: begin
                for (int i = 0; i < NumOut; i++) begin
                    w_rst_n_nxt[i] = (i < int'(w_idx_nxt));
                end
            end
            default: w_rst_n_nxt = '0;
        endcase
        w_active_nxt = ~&w_rst_n_nxt;
    end

    assign rst_no       = r_rst_n;
    assign rst_active_o = r_active;
    assign rst_cause_o  = r_cause;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NumOut=3, HoldCycles=8, StageGap=4, DebounceCycles=16.
module tb_rst_seq_ctrl;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         pll = 1'b1;
    logic         btn = 1'b0;
    logic         sw = 1'b0;
    logic [N-1:0] rst_no;
    logic         active;
    logic [1:0]   cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NumOut(3),
        .HoldCycles(8),
        .StageGap(4),
        .DebounceCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .pll_locked_i(pll),
        .rst_btn_i(btn),
        .sw_rst_req_i(sw),
        .rst_no(rst_no),
        .rst_active_o(active),
        .rst_cause_o(cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        pll   = 1'b0;
        ticks(3);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL reset_rst_no: got %b want 000", rst_no); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b want 1", active); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", cause); end
        rst_i = 1'b0;
        ticks(10);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL wait_lock_hold: got %b want 000", rst_no); end
        pll = 1'b1;
        ticks(10);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL wait_lock_early: got %b want 000", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL wait_lock_bit0: got %b want 001", rst_no); end
    endtask

    task automatic test_power_on();
        rst_i = 1'b1;
        ticks(2);
        rst_i = 1'b0;
        ticks(10);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL pwr_hold: got %b want 000", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL pwr_bit0: got %b want 001", rst_no); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL pwr_active_mid: got %b want 1", active); end
        ticks(3);
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL pwr_gap1: got %b want 001", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b011) begin errors++; $display("FAIL pwr_bit1: got %b want 011", rst_no); end
        ticks(3);
        checks++; if (rst_no !== 3'b011) begin errors++; $display("FAIL pwr_gap2: got %b want 011", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL pwr_bit2: got %b want 111", rst_no); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL pwr_active_run: got %b want 0", active); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL pwr_cause: got %0d want 0", cause); end
    endtask

    task automatic test_pll_loss();
        pll = 1'b0;
        tick();
        pll = 1'b1;
        tick();
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL pll_early: got %b want 111", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL pll_assert: got %b want 000", rst_no); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL pll_cause: got %0d want 1", cause); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL pll_active: got %b want 1", active); end
        ticks(9);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL pll_replay_hold: got %b want 000", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL pll_replay_bit0: got %b want 001", rst_no); end
        ticks(4);
        checks++; if (rst_no !== 3'b011) begin errors++; $display("FAIL pll_replay_bit1: got %b want 011", rst_no); end
        ticks(4);
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL pll_replay_bit2: got %b want 111", rst_no); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL pll_cause_hold: got %0d want 1", cause); end
    endtask

    task automatic test_button();
        for (int p = 0; p < 3; p++) begin
            btn = 1'b1;
            ticks(10);
            btn = 1'b0;
            ticks(10);
            checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL btn_bounce%0d: got %b want 111", p, rst_no); end
        end
        btn = 1'b1;
        ticks(17);
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL btn_early: got %b want 111", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL btn_assert: got %b want 000", rst_no); end
        checks++; if (cause !== 2'd2) begin errors++; $display("FAIL btn_cause: got %0d want 2", cause); end
        ticks(22);
        checks++; if (rst_no !== 3'b000 || active !== 1'b1) begin
            errors++; $display("FAIL btn_held: got %b/%b want 000/1", rst_no, active);
        end
        btn = 1'b0;
        ticks(27);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL btn_release_early: got %b want 000", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL btn_release_bit0: got %b want 001", rst_no); end
        ticks(8);
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL btn_run: got %b want 111", rst_no); end
        checks++; if (cause !== 2'd2) begin errors++; $display("FAIL btn_cause_hold: got %0d want 2", cause); end
    endtask

    task automatic test_software();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL sw_assert: got %b want 000", rst_no); end
        checks++; if (cause !== 2'd3) begin errors++; $display("FAIL sw_cause: got %0d want 3", cause); end
        ticks(3);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        ticks(5);
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL sw_hold_ignored_early: got %b want 000", rst_no); end
        tick();
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL sw_hold_ignored_bit0: got %b want 001", rst_no); end
        ticks(4);
        checks++; if (rst_no !== 3'b011) begin errors++; $display("FAIL sw_bit1: got %b want 011", rst_no); end
        ticks(4);
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL sw_run: got %b want 111", rst_no); end
    endtask

    task automatic test_abort();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        ticks(10);
        checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL abort_pre: got %b want 001", rst_no); end
        rst_i = 1'b1;
        tick();
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL abort_rst_no: got %b want 000", rst_no); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL abort_cause: got %0d want 0", cause); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL abort_active: got %b want 1", active); end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_priority();
        ticks(19);
        checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL prio_run: got %b want 111", rst_no); end
        pll = 1'b0;
        tick();
        pll = 1'b1;
        tick();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL prio_assert: got %b want 000", rst_no); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL prio_cause: got %0d want 1", cause); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_pll_loss();
        test_button();
        test_software();
        test_abort();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
